// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store sequencer for a word-addressed
// data memory. Sub-word stores use read-modify-write. Each accepted request
// produces one single-cycle response pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned requests skip memory and respond with resp_misaligned=1
//   undefined -> misaligned requests are forced to natural alignment and executed
module load_store_unit #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    output logic [ADDR_W-1:0] mem_addrs,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       write_data,
    input  logic [31:0]       read_data
);

    localparam int unsigned BA_W = ADDR_W + 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t      state;

    // Request fields held from acceptance until the next IDLE
    logic        write_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic [31:0] wdata_q;

    logic        accept_c;
    logic [1:0]  size_n_c;
    logic [1:0]  off_c;
    logic        trap_c;

    // Extract the addressed lane of a memory word and extend it
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {off, 3'b000};
        case (sz)
            SZ_BYTE: r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half lane of a word with right-aligned store data
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off,
                                                input logic [31:0] wd);
        logic [31:0] m;
        logic [31:0] d;
        case (sz)
            SZ_BYTE: begin
                m = 32'h0000_00FF << {off, 3'b000};
                d = {24'h0, wd[7:0]} << {off, 3'b000};
            end
            SZ_HALF: begin
                m = 32'h0000_FFFF << {off[1], 4'b0000};
                d = {16'h0, wd[15:0]} << {off[1], 4'b0000};
            end
            default: begin
                m = 32'hFFFF_FFFF;
                d = wd;
            end
        endcase
        return (w & ~m) | (d & m);
    endfunction

    // Request decode: size normalisation, lane offset alignment, trap decision
    always_comb begin
        accept_c = req_valid && req_ready;
        size_n_c = (req_size == 2'b11) ? SZ_WORD : req_size;
        case (size_n_c)
            SZ_HALF: off_c = {req_addr[1], 1'b0};
            SZ_WORD: off_c = 2'b00;
            default: off_c = req_addr[1:0];
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        trap_c = ((size_n_c == SZ_HALF) && req_addr[0]) ||
                 ((size_n_c == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        trap_c = 1'b0;
`endif
    end

    // Sequencer: state, latched request, memory strobes and response registers.
    // write_data doubles as the RMW word buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'h0;
            resp_misaligned <= 1'b0;
            mem_addrs       <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            write_data      <= 32'h0;
            write_q         <= 1'b0;
            size_q          <= SZ_BYTE;
            off_q           <= 2'b00;
            uns_q           <= 1'b0;
            wdata_q         <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        write_q   <= req_write;
                        size_q    <= size_n_c;
                        off_q     <= off_c;
                        uns_q     <= req_unsigned;
                        wdata_q   <= req_wdata;
                        mem_addrs <= req_addr[BA_W-1:2];
                        req_ready <= 1'b0;
                        if (trap_c) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= 32'h0;
                            resp_misaligned <= 1'b1;
                        end else if (req_write && (size_n_c == SZ_WORD)) begin
                            state      <= WRITE;
                            mem_write  <= 1'b1;
                            write_data <= req_wdata;
                        end else begin
                            state    <= READ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_read <= 1'b0;
                    if (write_q) begin
                        state      <= WRITE;
                        mem_write  <= 1'b1;
                        write_data <= store_merge(read_data, size_q, off_q, wdata_q);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_extract(read_data, size_q, off_q, uns_q);
                    end
                end
                WRITE: begin
                    mem_write  <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    state           <= IDLE;
                    req_ready       <= 1'b1;
                    resp_valid      <= 1'b0;
                    resp_rdata      <= 32'h0;
                    resp_misaligned <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [9:0]  mem_addrs;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the last transaction driven by do_req
    int          r_lat;
    logic [31:0] r_rd;
    logic        r_mis;
    logic        r_saw_rd;
    logic        r_saw_wr;
    logic [31:0] r_wdata;
    logic [9:0]  r_waddr;
    logic        r_both;

    logic [31:0] mem [0:1023];

    load_store_unit #(.ADDR_W(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_addrs       (mem_addrs),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .write_data      (write_data),
        .read_data       (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data = mem[mem_addrs];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addrs] <= write_data;
    end

    // Drive one request, wait for its response, record strobes seen meanwhile
    task automatic do_req(input logic wr, input logic [11:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd);
        int k;
        @(negedge clk);
        req_write    = wr;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        req_valid    = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = 32'h0;
        req_addr  = 12'h0;
        r_lat = -1; r_rd = 32'hX; r_mis = 1'bX;
        r_saw_rd = 1'b0; r_saw_wr = 1'b0; r_both = 1'b0;
        r_wdata = 32'h0; r_waddr = 10'h0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (mem_read) r_saw_rd = 1'b1;
            if (mem_read && mem_write) r_both = 1'b1;
            if (mem_write) begin
                r_saw_wr = 1'b1;
                r_wdata  = write_data;
                r_waddr  = mem_addrs;
            end
            if (resp_valid) begin
                r_lat = cyc;
                r_rd  = resp_rdata;
                r_mis = resp_misaligned;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({req_ready, resp_valid, resp_misaligned, mem_read, mem_write} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 10000",
                     {req_ready, resp_valid, resp_misaligned, mem_read, mem_write});
        end
        n_cmp++;
        if ({resp_rdata, write_data, mem_addrs} !== 74'h0) begin
            n_err++;
            $display("FAIL reset_data: rdata=%h wdata=%h addr=%0d want 0", resp_rdata, write_data, mem_addrs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_store();
        do_req(1'b1, 12'h028, 2'b10, 1'b0, 32'h12345678);
        n_cmp++;
        if (r_lat !== 2) begin n_err++; $display("FAIL wstore_lat: got %0d want 2", r_lat); end
        n_cmp++;
        if ({r_saw_rd, r_saw_wr, r_both} !== 3'b010) begin
            n_err++; $display("FAIL wstore_strobes: rd/wr/both=%b want 010", {r_saw_rd, r_saw_wr, r_both});
        end
        n_cmp++;
        if (r_waddr !== 10'd10 || r_wdata !== 32'h12345678) begin
            n_err++; $display("FAIL wstore_data: addr=%0d data=%h want 10/12345678", r_waddr, r_wdata);
        end
        n_cmp++;
        if (r_rd !== 32'h0) begin n_err++; $display("FAIL wstore_rdata: got %h want 0", r_rd); end
        do_req(1'b0, 12'h028, 2'b10, 1'b0, 32'h0);
        n_cmp++;
        if (r_rd !== 32'h12345678 || r_lat !== 2) begin
            n_err++; $display("FAIL wload: got %h lat %0d want 12345678 lat 2", r_rd, r_lat);
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
            n_err++; $display("FAIL resp_clear: valid=%b rdata=%h want 0/0", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_load_ext();
        do_req(1'b1, 12'h050, 2'b10, 1'b0, 32'hDEADBEEF);
        do_req(1'b0, 12'h050, 2'b00, 1'b0, 32'h0);
        n_cmp++;
        if (r_rd !== 32'hFFFFFFEF) begin n_err++; $display("FAIL lb: got %h want FFFFFFEF", r_rd); end
        do_req(1'b0, 12'h050, 2'b00, 1'b1, 32'h0);
        n_cmp++;
        if (r_rd !== 32'h000000EF) begin n_err++; $display("FAIL lbu: got %h want 000000EF", r_rd); end
        do_req(1'b0, 12'h052, 2'b01, 1'b0, 32'h0);
        n_cmp++;
        if (r_rd !== 32'hFFFFDEAD) begin n_err++; $display("FAIL lh: got %h want FFFFDEAD", r_rd); end
        do_req(1'b0, 12'h052, 2'b01, 1'b1, 32'h0);
        n_cmp++;
        if (r_rd !== 32'h0000DEAD) begin n_err++; $display("FAIL lhu: got %h want 0000DEAD", r_rd); end
        do_req(1'b0, 12'h053, 2'b00, 1'b1, 32'h0);
        n_cmp++;
        if (r_rd !== 32'h000000DE) begin n_err++; $display("FAIL lbu3: got %h want 000000DE", r_rd); end
    endtask

    task automatic test_rmw();
        do_req(1'b1, 12'h029, 2'b00, 1'b0, 32'hFFFFFFAA);
        n_cmp++;
        if (r_lat !== 3 || r_saw_rd !== 1'b1 || r_both !== 1'b0) begin
            n_err++; $display("FAIL sb_seq: lat=%0d rd=%b both=%b want 3/1/0", r_lat, r_saw_rd, r_both);
        end
        n_cmp++;
        if (r_wdata !== 32'h1234AA78 || r_waddr !== 10'd10) begin
            n_err++; $display("FAIL sb_data: got %h @%0d want 1234AA78 @10", r_wdata, r_waddr);
        end
        do_req(1'b1, 12'h02A, 2'b01, 1'b0, 32'h0000BEEF);
        n_cmp++;
        if (r_wdata !== 32'hBEEFAA78 || r_lat !== 3) begin
            n_err++; $display("FAIL sh_data: got %h lat %0d want BEEFAA78 lat 3", r_wdata, r_lat);
        end
        do_req(1'b0, 12'h028, 2'b11, 1'b0, 32'h0);
        n_cmp++;
        if (r_rd !== 32'hBEEFAA78) begin n_err++; $display("FAIL rmw_readback: got %h want BEEFAA78", r_rd); end
    endtask

    task automatic test_misaligned();
        do_req(1'b0, 12'h02A, 2'b10, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_cmp++;
        if (r_lat !== 1 || r_mis !== 1'b1 || r_rd !== 32'h0) begin
            n_err++; $display("FAIL mis_trap: lat=%0d mis=%b rdata=%h want 1/1/0", r_lat, r_mis, r_rd);
        end
        n_cmp++;
        if (r_saw_rd !== 1'b0 || r_saw_wr !== 1'b0) begin
            n_err++; $display("FAIL mis_strobes: rd=%b wr=%b want 0/0", r_saw_rd, r_saw_wr);
        end
`else
        n_cmp++;
        if (r_lat !== 2 || r_mis !== 1'b0 || r_rd !== 32'hBEEFAA78) begin
            n_err++; $display("FAIL mis_align: lat=%0d mis=%b rdata=%h want 2/0/BEEFAA78", r_lat, r_mis, r_rd);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int acc;
        int pulses;
        int acc_cyc [2];
        int low_cnt;
        acc = 0; pulses = 0; low_cnt = 0;
        acc_cyc[0] = -1; acc_cyc[1] = -1;
        @(negedge clk);
        req_write = 1'b0; req_addr = 12'h028; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            req_valid = (acc < 2);
            if (resp_valid) pulses++;
            if (!req_ready) low_cnt++;
            if (req_valid && req_ready) begin
                acc_cyc[acc] = i;
                acc++;
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (acc_cyc[0] !== 0 || acc_cyc[1] !== 3) begin
            n_err++; $display("FAIL b2b_accept: cycles %0d,%0d want 0,3", acc_cyc[0], acc_cyc[1]);
        end
        n_cmp++;
        if (pulses !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        n_cmp++;
        if (low_cnt !== 4) begin n_err++; $display("FAIL b2b_ready_low: got %0d want 4", low_cnt); end
    endtask

    task automatic test_reset_rmw();
        int bad;
        bad = 0;
        @(negedge clk);
        req_write = 1'b1; req_addr = 12'h029; req_size = 2'b00; req_wdata = 32'h00000011;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_cmp++;
        if (mem_read !== 1'b1) begin n_err++; $display("FAIL rst_pre_read: got %b want 1", mem_read); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_read, mem_write, resp_valid, req_ready} !== 4'b0001 || mem_addrs !== 10'h0) begin
            n_err++; $display("FAIL rst_async: rd/wr/rv/rdy=%b addr=%0d want 0001/0",
                              {mem_read, mem_write, resp_valid, req_ready}, mem_addrs);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (resp_valid || mem_write || mem_read) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL rst_activity: got %0d want 0", bad); end
        n_cmp++;
        if (mem[10] !== 32'hBEEFAA78 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mem: word10=%h ready=%b want BEEFAA78/1", mem[10], req_ready);
        end
        do_req(1'b0, 12'h028, 2'b10, 1'b0, 32'h0);
        n_cmp++;
        if (r_rd !== 32'hBEEFAA78) begin n_err++; $display("FAIL rst_reload: got %h want BEEFAA78", r_rd); end
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 12'h0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        test_reset();
        test_word_store();
        test_load_ext();
        test_rmw();
        test_misaligned();
        test_back_to_back();
        test_reset_rmw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bus master for the word-addressed data memory. It accepts byte-addressed load/store requests from the execute stage (byte, halfword and word size, signed or unsigned loads) and sequences `mem_read`/`mem_write` cycles on the memory port. Sub-word stores use read-modify-write. Each accepted request produces exactly one single-cycle response pulse back to the pipeline.

## Interface
Parameters:
- ADDR_W, 10, memory word-address width; the byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  rising-edge clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge with req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W+2  byte address, little-endian within a word
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  32  extended load result; 0 for stores
- resp_misaligned  out  1  valid with resp_valid
- mem_addrs  out  ADDR_W  word address, equal to req_addr[ADDR_W+1:2]
- mem_read  out  1  memory read strobe; the memory drives read_data combinationally during this cycle
- mem_write  out  1  memory write strobe; the memory writes write_data on the rising edge
- write_data  out  32  store word to memory
- read_data  in  32  memory read word

## Operation
- States: IDLE, READ, WRITE, RESP.
- Request latching: request fields are captured on acceptance and held until the following IDLE. Input changes after acceptance are ignored.
- IDLE transitions on acceptance:
  - misaligned request → RESP
  - load → READ
  - word store → WRITE
  - byte/half store → READ
- READ: mem_read=1. read_data is registered into an internal word buffer at the end of the cycle. Next state is RESP for a load, or WRITE for a sub-word store.
- WRITE: mem_write=1. Next state is RESP.
  - Word store: write_data = req_wdata.
  - Sub-word store: write_data = buffer with only the addressed byte/half lane replaced.
- RESP: resp_valid=1, then IDLE.
- Load extraction uses byte lane addr[1:0] and half lane addr[1].
  - Sign extension from bit 7 (byte) or bit 15 (half) when req_unsigned=0.
  - Word loads are returned unchanged.
- Misalignment is defined as half with addr[0]=1, or word with addr[1:0]≠0.
- mem_read and mem_write are decoded from state. They are never high together and are never high in IDLE or RESP.

## Timing
- Reset state: IDLE. resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_read=0, mem_write=0, mem_addrs=0, write_data=0, req_ready=1.
- Latency from acceptance edge to resp_valid high:
  - load: 2 cycles (READ, RESP)
  - word store: 2 cycles (WRITE, RESP)
  - sub-word store: 3 cycles (READ, WRITE, RESP)
  - misaligned: 1 cycle
- Throughput: the next request can be accepted on the edge that ends RESP+1, i.e. the first IDLE cycle. There is no overlap between requests.
- mem_addrs and write_data are registered. They are stable for the whole strobe cycle and hold their value afterwards.
- Reset asserted mid-operation:
  - all outputs go to their reset values immediately, whatever the clock;
  - a pending strobe is dropped, and no partial RMW write occurs unless its WRITE edge already passed;
  - no response is issued for the aborted request.
- resp_rdata and resp_misaligned are valid only while resp_valid=1. They are cleared to 0 in the cycle after.

## Configuration
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - misaligned requests skip memory entirely;
  - the response carries resp_misaligned=1 and resp_rdata=0;
  - memory contents are unchanged.
- Undefined:
  - resp_misaligned is tied 0;
  - misaligned half/word accesses are forced to natural alignment (addr[0] cleared for half, addr[1:0] cleared for word) and executed normally.

## Test plan
- Word store and readback:
  - Store word 0x12345678 at byte 0x028 → the WRITE cycle shows mem_addrs=10, write_data=0x12345678, mem_write=1; resp_valid 2 cycles after acceptance.
  - Load word from 0x028 → resp_rdata=0x12345678.
- Load extension: store word 0xDEADBEEF at 0x050 (word 20), then:
  - signed byte load from 0x050 → 0xFFFFFFEF
  - unsigned byte load from 0x050 → 0x000000EF
  - signed half load from 0x052 → 0xFFFFDEAD
  - unsigned half load from 0x052 → 0x0000DEAD
- Sub-word RMW store:
  - Store byte 0xAA at 0x029 over 0x12345678 → a READ cycle, then a WRITE cycle with write_data=0x1234AA78.
  - Store half 0xBEEF at 0x02A → write_data=0xBEEFAA78.
  - resp_valid 3 cycles after acceptance.
- Misaligned word load from 0x02A:
  - with LSU_MISALIGN_TRAP_EN → resp_misaligned=1, resp_rdata=0, no mem_read or mem_write, response 1 cycle after acceptance;
  - without the macro → resp_rdata equals the word-10 contents.
- Back-to-back handshake:
  - Hold req_valid=1 across two loads → req_ready=0 from acceptance through RESP.
  - The second request is accepted only in the next IDLE cycle; exactly two resp_valid pulses.
- Reset during RMW:
  - Drive rst_n=0 during the READ cycle of a byte store to 0x029 → mem_read drops immediately.
  - Memory word 10 is unchanged and no resp_valid appears.
  - After release, req_ready=1 and a new load from 0x028 returns the prior value.
